cq_mirror_fifo: RTL and testbench

// - Sits on the PCIe completer-request (CQ) AXI-stream between pcie_top and the CQ consumer.
// - Passes every beat through unchanged.
// - Copies whole TLPs into a packet FIFO that feeds the Ethernet TX stream into eth_top.
// - Only complete TLPs become visible on the TX side; a TLP that does not fit is dropped whole and counted.
// - The primary CQ path is never throttled by the mirror.

---
 rtl/utlp_pkg.sv | 22 ++
 rtl/cq_mirror_ram.sv | 34 +++
 rtl/cq_mirror_fifo.sv | 222 ++++++++++++++++++++++
 tb/tb_cq_mirror_fifo.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/utlp_pkg.sv
// Shared types and constants for the CQ mirror path.
package utlp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COPY = 2'd1,
        DROP = 2'd2
    } mirror_state_e;

    localparam int CQ_TUSER_WIDTH = 85;
    localparam int CQ_READY_WIDTH = 22;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        if (value == 32'hFFFF_FFFF) begin
            sat_inc32 = value;
        end else begin
            sat_inc32 = value + 32'd1;
        end
    endfunction

endpackage

// File: rtl/cq_mirror_ram.sv
// Simple dual-port storage for the mirror FIFO: one write port, one read
// port with a single registered read stage. Contents are never reset; the
// FIFO pointers decide which entries are meaningful.
module cq_mirror_ram #(
    parameter int WIDTH = 67,
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write port: store a beat when the mirror FSM accepts it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read port: one-cycle registered read issued by the output prefetch.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/cq_mirror_fifo.sv
// CQ AXI-stream tap: passes every CQ beat straight through to the consumer
// and copies whole TLPs into a packet FIFO feeding the Ethernet TX stream.
// Beats are written speculatively and only become readable when the TLP's
// last beat lands; a TLP that runs out of space is rolled back and counted.
module cq_mirror_fifo
    import utlp_pkg::*;
#(
    parameter int C_DATA_WIDTH = 64,
    parameter int KEEP_WIDTH   = C_DATA_WIDTH / 32,
    parameter int TUSER_WIDTH  = CQ_TUSER_WIDTH,
    parameter int FIFO_DEPTH   = 512,
    parameter int READY_WIDTH  = CQ_READY_WIDTH
) (
    input  logic                             user_clk,
    input  logic                             sys_rst_n,
    input  logic [C_DATA_WIDTH-1:0]          s_axis_cq_tdata,
    input  logic [TUSER_WIDTH-1:0]           s_axis_cq_tuser,
    input  logic [KEEP_WIDTH-1:0]            s_axis_cq_tkeep,
    input  logic                             s_axis_cq_tlast,
    input  logic                             s_axis_cq_tvalid,
    output logic [READY_WIDTH-1:0]           s_axis_cq_tready,
    output logic [C_DATA_WIDTH-1:0]          m_axis_cq_tdata,
    output logic [TUSER_WIDTH-1:0]           m_axis_cq_tuser,
    output logic [KEEP_WIDTH-1:0]            m_axis_cq_tkeep,
    output logic                             m_axis_cq_tlast,
    output logic                             m_axis_cq_tvalid,
    input  logic                             m_axis_cq_tready,
    output logic [C_DATA_WIDTH-1:0]          m_axis_tx_tdata,
    output logic [KEEP_WIDTH-1:0]            m_axis_tx_tkeep,
    output logic                             m_axis_tx_tlast,
    output logic                             m_axis_tx_tvalid,
    input  logic                             m_axis_tx_tready,
    input  logic                             mirror_en,
    output logic [31:0]                      pkt_count,
    output logic [31:0]                      drop_count,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int RW = KEEP_WIDTH + C_DATA_WIDTH + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(32'd1);
    localparam logic [PW-1:0] PTR_TWO = PW'(32'd2);

    // Write-side state
    mirror_state_e   state_r;
    logic [PW-1:0]   wr_spec_r;
    logic [PW-1:0]   wr_commit_r;
    logic [31:0]     pkt_count_r;
    logic [31:0]     drop_count_r;

    // Read-side state: rd_r counts beats handed to eth_top, fetch_r counts
    // beats pulled out of the RAM into the output pipeline.
    logic [PW-1:0]   rd_r;
    logic [PW-1:0]   fetch_r;
    logic            pend_r;
    logic            out_v_r;
    logic [RW-1:0]   out_r;
    logic            skid_v_r;
    logic [RW-1:0]   skid_r;

    logic            accept_s;
    logic [PW-1:0]   used_s;
    logic            full_s;
    logic            wr_en_s;
    logic            pop_s;
    logic            avail_s;
    logic [PW-1:0]   occ_s;
    logic            rd_en_s;
    logic [RW-1:0]   ram_rdata_s;

    // The primary path is a wire-through; the mirror never back-pressures it.
    assign m_axis_cq_tdata  = s_axis_cq_tdata;
    assign m_axis_cq_tuser  = s_axis_cq_tuser;
    assign m_axis_cq_tkeep  = s_axis_cq_tkeep;
    assign m_axis_cq_tlast  = s_axis_cq_tlast;
    assign m_axis_cq_tvalid = s_axis_cq_tvalid;
    assign s_axis_cq_tready = {READY_WIDTH{m_axis_cq_tready}};

    assign accept_s = s_axis_cq_tvalid & m_axis_cq_tready;

    // Occupancy counts speculative beats and beats still held in the output
    // stage, so nothing in flight can be overwritten. MSB set means full.
    assign used_s = wr_spec_r - rd_r;
    assign full_s = used_s[PW-1];

    // A beat is stored when starting an enabled TLP or continuing one, with space.
    always_comb begin
        wr_en_s = 1'b0;
        if (accept_s && !full_s) begin
            case (state_r)
                IDLE:    wr_en_s = mirror_en;
                COPY:    wr_en_s = 1'b1;
                default: wr_en_s = 1'b0;
            endcase
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Mirror FSM: speculative write pointer, commit/rollback and counters.
    always_ff @(posedge user_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r      <= IDLE;
            wr_spec_r    <= '0;
            wr_commit_r  <= '0;
            pkt_count_r  <= 32'd0;
            drop_count_r <= 32'd0;
        end else if (accept_s) begin
            case (state_r)
                IDLE: begin
                    if (mirror_en) begin
                        if (!full_s) begin
                            wr_spec_r <= wr_spec_r + PTR_ONE;
                            if (s_axis_cq_tlast) begin
                                wr_commit_r <= wr_spec_r + PTR_ONE;
                                pkt_count_r <= sat_inc32(pkt_count_r);
                            end else begin
                                state_r <= COPY;
                            end
                        end else begin
                            drop_count_r <= sat_inc32(drop_count_r);
                            state_r      <= s_axis_cq_tlast ? IDLE : DROP;
                        end
                    end else begin
                        // Mirroring disabled at TLP start: skip it silently.
                        state_r <= s_axis_cq_tlast ? IDLE : DROP;
                    end
                end
                COPY: begin
                    if (!full_s) begin
                        wr_spec_r <= wr_spec_r + PTR_ONE;
                        if (s_axis_cq_tlast) begin
                            wr_commit_r <= wr_spec_r + PTR_ONE;
                            pkt_count_r <= sat_inc32(pkt_count_r);
                            state_r     <= IDLE;
                        end else begin
                            state_r <= COPY;
                        end
                    end else begin
                        // Out of space mid-TLP: discard the partial copy.
                        wr_spec_r    <= wr_commit_r;
                        drop_count_r <= sat_inc32(drop_count_r);
                        state_r      <= s_axis_cq_tlast ? IDLE : DROP;
                    end
                end
                DROP: begin
                    state_r <= s_axis_cq_tlast ? IDLE : DROP;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    cq_mirror_ram #(
        .WIDTH (RW),
        .DEPTH (FIFO_DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (user_clk),
        .we    (wr_en_s),
        .waddr (wr_spec_r[AW-1:0]),
        .wdata ({s_axis_cq_tkeep, s_axis_cq_tdata, s_axis_cq_tlast}),
        .re    (rd_en_s),
        .raddr (fetch_r[AW-1:0]),
        .rdata (ram_rdata_s)
    );

    // Prefetch keeps at most two beats (output + skid, including one read in
    // flight) ahead of the consumer; this hides the RAM latency without bubbles.
    assign pop_s   = out_v_r & m_axis_tx_tready;
    assign avail_s = (fetch_r != wr_commit_r);
    assign occ_s   = fetch_r - rd_r;
    assign rd_en_s = avail_s && ((occ_s - {{(PW-1){1'b0}}, pop_s}) < PTR_TWO);

    // Output stage and skid register: oldest beat in out_r, next in skid_r.
    always_ff @(posedge user_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_r     <= '0;
            fetch_r  <= '0;
            pend_r   <= 1'b0;
            out_v_r  <= 1'b0;
            out_r    <= '0;
            skid_v_r <= 1'b0;
            skid_r   <= '0;
        end else begin
            pend_r  <= rd_en_s;
            fetch_r <= fetch_r + {{(PW-1){1'b0}}, rd_en_s};
            rd_r    <= rd_r + {{(PW-1){1'b0}}, pop_s};
            if (pop_s) begin
                if (skid_v_r) begin
                    out_r    <= skid_r;
                    skid_v_r <= pend_r;
                    if (pend_r) begin
                        skid_r <= ram_rdata_s;
                    end
                end else if (pend_r) begin
                    out_r <= ram_rdata_s;
                end else begin
                    out_v_r <= 1'b0;
                end
            end else if (pend_r) begin
                if (!out_v_r) begin
                    out_r   <= ram_rdata_s;
                    out_v_r <= 1'b1;
                end else begin
                    skid_r   <= ram_rdata_s;
                    skid_v_r <= 1'b1;
                end
            end
        end
    end

    assign {m_axis_tx_tkeep, m_axis_tx_tdata, m_axis_tx_tlast} = out_r;
    assign m_axis_tx_tvalid = out_v_r;
    assign pkt_count        = pkt_count_r;
    assign drop_count       = drop_count_r;
    assign fifo_level       = wr_commit_r - rd_r;

endmodule

// File: tb/tb_cq_mirror_fifo.sv
// Scenario bench for cq_mirror_fifo with a 16-beat FIFO. Stimulus tasks push
// the beats they expect to see mirrored; a negedge monitor pops and compares
// every TX handshake and checks that stalled beats are held stable.
`timescale 1ns/1ps
module tb_cq_mirror_fifo;
    import utlp_pkg::*;

    localparam int DW    = 64;
    localparam int KW    = DW / 32;
    localparam int TW    = 85;
    localparam int DEPTH = 16;
    localparam int RDW   = 22;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int BW    = KW + DW + 1;

    logic            user_clk = 1'b0;
    logic            sys_rst_n;
    logic [DW-1:0]   s_axis_cq_tdata;
    logic [TW-1:0]   s_axis_cq_tuser;
    logic [KW-1:0]   s_axis_cq_tkeep;
    logic            s_axis_cq_tlast;
    logic            s_axis_cq_tvalid;
    logic [RDW-1:0]  s_axis_cq_tready;
    logic [DW-1:0]   m_axis_cq_tdata;
    logic [TW-1:0]   m_axis_cq_tuser;
    logic [KW-1:0]   m_axis_cq_tkeep;
    logic            m_axis_cq_tlast;
    logic            m_axis_cq_tvalid;
    logic            m_axis_cq_tready;
    logic [DW-1:0]   m_axis_tx_tdata;
    logic [KW-1:0]   m_axis_tx_tkeep;
    logic            m_axis_tx_tlast;
    logic            m_axis_tx_tvalid;
    logic            m_axis_tx_tready;
    logic            mirror_en;
    logic [31:0]     pkt_count;
    logic [31:0]     drop_count;
    logic [LW-1:0]   fifo_level;

    logic [BW-1:0]   exp_q[$];
    int              n_checks = 0;
    int              n_pass   = 0;
    int              exp_pkt  = 0;
    int              exp_drop = 0;
    logic            prev_stall = 1'b0;
    logic [BW-1:0]   prev_beat  = '0;
    logic [BW-1:0]   cur_beat;
    logic [BW-1:0]   want_beat;

    always #5 user_clk = ~user_clk;

    cq_mirror_fifo #(
        .C_DATA_WIDTH (DW),
        .KEEP_WIDTH   (KW),
        .TUSER_WIDTH  (TW),
        .FIFO_DEPTH   (DEPTH),
        .READY_WIDTH  (RDW)
    ) dut (
        .user_clk         (user_clk),
        .sys_rst_n        (sys_rst_n),
        .s_axis_cq_tdata  (s_axis_cq_tdata),
        .s_axis_cq_tuser  (s_axis_cq_tuser),
        .s_axis_cq_tkeep  (s_axis_cq_tkeep),
        .s_axis_cq_tlast  (s_axis_cq_tlast),
        .s_axis_cq_tvalid (s_axis_cq_tvalid),
        .s_axis_cq_tready (s_axis_cq_tready),
        .m_axis_cq_tdata  (m_axis_cq_tdata),
        .m_axis_cq_tuser  (m_axis_cq_tuser),
        .m_axis_cq_tkeep  (m_axis_cq_tkeep),
        .m_axis_cq_tlast  (m_axis_cq_tlast),
        .m_axis_cq_tvalid (m_axis_cq_tvalid),
        .m_axis_cq_tready (m_axis_cq_tready),
        .m_axis_tx_tdata  (m_axis_tx_tdata),
        .m_axis_tx_tkeep  (m_axis_tx_tkeep),
        .m_axis_tx_tlast  (m_axis_tx_tlast),
        .m_axis_tx_tvalid (m_axis_tx_tvalid),
        .m_axis_tx_tready (m_axis_tx_tready),
        .mirror_en        (mirror_en),
        .pkt_count        (pkt_count),
        .drop_count       (drop_count),
        .fifo_level       (fifo_level)
    );

    // TX monitor: scoreboard pop on handshake, hold check after a stall.
    always @(negedge user_clk) begin
        cur_beat = {m_axis_tx_tkeep, m_axis_tx_tdata, m_axis_tx_tlast};
        if (!sys_rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                n_checks++;
                if (m_axis_tx_tvalid !== 1'b1 || cur_beat !== prev_beat)
                    $display("FAIL tx_hold: got valid=%0b beat=%h, required valid=1 beat=%h",
                             m_axis_tx_tvalid, cur_beat, prev_beat);
                else n_pass++;
            end
            if (m_axis_tx_tvalid && m_axis_tx_tready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL tx_unexpected: got beat=%h, required no beat", cur_beat);
                end else begin
                    want_beat = exp_q.pop_front();
                    if (cur_beat !== want_beat)
                        $display("FAIL tx_beat: got %h, required %h", cur_beat, want_beat);
                    else n_pass++;
                end
            end
            prev_stall = m_axis_tx_tvalid && !m_axis_tx_tready;
            prev_beat  = cur_beat;
        end
    end

    task automatic tick();
        @(posedge user_clk);
        #1;
    endtask

    // Drive one TLP on CQ; optionally record its beats as expected TX output.
    task automatic send_tlp(input int n, input bit en_first, input bit en_rest, input bit push);
        for (int i = 0; i < n; i++) begin
            s_axis_cq_tdata  = {$urandom, $urandom};
            s_axis_cq_tkeep  = KW'($urandom_range(32'd1, 32'd3));
            s_axis_cq_tuser  = TW'($urandom);
            s_axis_cq_tlast  = (i == n - 1);
            s_axis_cq_tvalid = 1'b1;
            mirror_en        = (i == 0) ? en_first : en_rest;
            #1;
            n_checks++;
            if (s_axis_cq_tready !== {RDW{1'b1}} || m_axis_cq_tvalid !== 1'b1 ||
                m_axis_cq_tdata !== s_axis_cq_tdata || m_axis_cq_tlast !== s_axis_cq_tlast)
                $display("FAIL cq_pass: got ready=%h valid=%0b data=%h, required ready=%h valid=1 data=%h",
                         s_axis_cq_tready, m_axis_cq_tvalid, m_axis_cq_tdata, {RDW{1'b1}}, s_axis_cq_tdata);
            else n_pass++;
            if (push) exp_q.push_back({s_axis_cq_tkeep, s_axis_cq_tdata, s_axis_cq_tlast});
            tick();
        end
        s_axis_cq_tvalid = 1'b0;
        s_axis_cq_tlast  = 1'b0;
    endtask

    // Bounded wait for the scoreboard to empty, then let the last pop settle.
    task automatic wait_drain();
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 300) begin
            tick();
            cyc++;
        end
        repeat (3) tick();
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL drain_timeout: got %0d beats outstanding, required 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        sys_rst_n        = 1'b0;
        m_axis_cq_tready = 1'b1;
        m_axis_tx_tready = 1'b1;
        mirror_en        = 1'b1;
        s_axis_cq_tdata  = 64'h0123_4567_89AB_CDEF;
        s_axis_cq_tuser  = 85'h1_2345_6789;
        s_axis_cq_tkeep  = 2'b10;
        s_axis_cq_tlast  = 1'b1;
        s_axis_cq_tvalid = 1'b1;
        #13;
        n_checks++;
        if (m_axis_tx_tvalid !== 1'b0 || pkt_count !== 32'd0 || drop_count !== 32'd0 || fifo_level !== LW'(0))
            $display("FAIL reset_state: got valid=%0b pkt=%0d drop=%0d level=%0d, required 0 0 0 0",
                     m_axis_tx_tvalid, pkt_count, drop_count, fifo_level);
        else n_pass++;
        n_checks++;
        if (m_axis_cq_tdata !== 64'h0123_4567_89AB_CDEF || m_axis_cq_tuser !== 85'h1_2345_6789 ||
            m_axis_cq_tkeep !== 2'b10 || m_axis_cq_tlast !== 1'b1 || m_axis_cq_tvalid !== 1'b1)
            $display("FAIL reset_passthru: got data=%h keep=%b, required data=0123456789abcdef keep=10",
                     m_axis_cq_tdata, m_axis_cq_tkeep);
        else n_pass++;
        m_axis_cq_tready = 1'b0;
        #1;
        n_checks++;
        if (s_axis_cq_tready !== {RDW{1'b0}})
            $display("FAIL ready_fanout: got %h, required 0", s_axis_cq_tready);
        else n_pass++;
        m_axis_cq_tready = 1'b1;
        s_axis_cq_tvalid = 1'b0;
        s_axis_cq_tlast  = 1'b0;
        @(negedge user_clk);
        sys_rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_basic();
        m_axis_tx_tready = 1'b1;
        send_tlp(3, 1'b1, 1'b1, 1'b1);
        exp_pkt++;
        wait_drain();
        n_checks++;
        if (pkt_count !== 32'(exp_pkt) || fifo_level !== LW'(0) || drop_count !== 32'(exp_drop))
            $display("FAIL basic: got pkt=%0d level=%0d drop=%0d, required pkt=%0d level=0 drop=%0d",
                     pkt_count, fifo_level, drop_count, exp_pkt, exp_drop);
        else n_pass++;
    endtask

    task automatic test_fill();
        m_axis_tx_tready = 1'b0;
        for (int t = 0; t < 4; t++) send_tlp(4, 1'b1, 1'b1, 1'b1);
        send_tlp(4, 1'b1, 1'b1, 1'b0);
        exp_pkt  += 4;
        exp_drop += 1;
        tick();
        n_checks++;
        if (fifo_level !== LW'(16) || drop_count !== 32'(exp_drop) || pkt_count !== 32'(exp_pkt))
            $display("FAIL fill: got level=%0d drop=%0d pkt=%0d, required level=16 drop=%0d pkt=%0d",
                     fifo_level, drop_count, pkt_count, exp_drop, exp_pkt);
        else n_pass++;
        m_axis_tx_tready = 1'b1;
        wait_drain();
        n_checks++;
        if (fifo_level !== LW'(0))
            $display("FAIL fill_drain: got level=%0d, required 0", fifo_level);
        else n_pass++;
    endtask

    task automatic test_rollback();
        m_axis_tx_tready = 1'b0;
        for (int t = 0; t < 3; t++) send_tlp(4, 1'b1, 1'b1, 1'b1);
        exp_pkt += 3;
        send_tlp(5, 1'b1, 1'b1, 1'b0);
        exp_drop += 1;
        tick();
        n_checks++;
        if (fifo_level !== LW'(12) || drop_count !== 32'(exp_drop) || pkt_count !== 32'(exp_pkt))
            $display("FAIL rollback: got level=%0d drop=%0d pkt=%0d, required level=12 drop=%0d pkt=%0d",
                     fifo_level, drop_count, pkt_count, exp_drop, exp_pkt);
        else n_pass++;
        m_axis_tx_tready = 1'b1;
        wait_drain();
        send_tlp(2, 1'b1, 1'b1, 1'b1);
        exp_pkt++;
        wait_drain();
        n_checks++;
        if (pkt_count !== 32'(exp_pkt) || fifo_level !== LW'(0))
            $display("FAIL rollback_recover: got pkt=%0d level=%0d, required pkt=%0d level=0",
                     pkt_count, fifo_level, exp_pkt);
        else n_pass++;
    endtask

    task automatic test_mirror_en();
        m_axis_tx_tready = 1'b1;
        send_tlp(4, 1'b1, 1'b0, 1'b1);
        send_tlp(3, 1'b0, 1'b0, 1'b0);
        exp_pkt++;
        wait_drain();
        n_checks++;
        if (pkt_count !== 32'(exp_pkt) || drop_count !== 32'(exp_drop) || fifo_level !== LW'(0))
            $display("FAIL mirror_en: got pkt=%0d drop=%0d level=%0d, required pkt=%0d drop=%0d level=0",
                     pkt_count, drop_count, fifo_level, exp_pkt, exp_drop);
        else n_pass++;
    endtask

    task automatic test_tready_toggle();
        m_axis_tx_tready = 1'b0;
        send_tlp(8, 1'b1, 1'b1, 1'b1);
        exp_pkt++;
        for (int i = 0; i < 64 && exp_q.size() != 0; i++) begin
            m_axis_tx_tready = (i % 2 == 0);
            tick();
        end
        m_axis_tx_tready = 1'b1;
        wait_drain();
        n_checks++;
        if (pkt_count !== 32'(exp_pkt) || fifo_level !== LW'(0) || m_axis_tx_tvalid !== 1'b0)
            $display("FAIL toggle_end: got pkt=%0d level=%0d valid=%0b, required pkt=%0d level=0 valid=0",
                     pkt_count, fifo_level, m_axis_tx_tvalid, exp_pkt);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        m_axis_tx_tready = 1'b0;
        send_tlp(2, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            s_axis_cq_tdata  = {$urandom, $urandom};
            s_axis_cq_tkeep  = 2'b11;
            s_axis_cq_tlast  = 1'b0;
            s_axis_cq_tvalid = 1'b1;
            mirror_en        = 1'b1;
            tick();
        end
        s_axis_cq_tvalid = 1'b0;
        sys_rst_n = 1'b0;
        exp_q.delete();
        exp_pkt  = 0;
        exp_drop = 0;
        #1;
        n_checks++;
        if (m_axis_tx_tvalid !== 1'b0 || fifo_level !== LW'(0) || pkt_count !== 32'd0 || drop_count !== 32'd0)
            $display("FAIL reset_mid: got valid=%0b level=%0d pkt=%0d drop=%0d, required 0 0 0 0",
                     m_axis_tx_tvalid, fifo_level, pkt_count, drop_count);
        else n_pass++;
        @(negedge user_clk);
        sys_rst_n = 1'b1;
        tick();
        m_axis_tx_tready = 1'b1;
        send_tlp(3, 1'b1, 1'b1, 1'b1);
        exp_pkt++;
        wait_drain();
        n_checks++;
        if (pkt_count !== 32'(exp_pkt) || fifo_level !== LW'(0) || drop_count !== 32'd0)
            $display("FAIL reset_recover: got pkt=%0d level=%0d drop=%0d, required pkt=%0d level=0 drop=0",
                     pkt_count, fifo_level, drop_count, exp_pkt);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_rollback();
        test_mirror_en();
        test_tready_toggle();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
